cpu_bus_control: RTL and testbench
==================================

// Module: cpu_bus_control
// PURPOSE
// Owns the CPU's 4-bit multiplexed external bus and the CM-ROM/CM-RAM command lines.
// Each instruction cycle it decides who drives the bus: PC or index registers for address,
// ROM for opcode, and CPU or peripheral for I/O. It sits beside cpu_control and the
// datapath, keyed off the shared 3-bit subcycle counter.
// Subcycles: 0=A1, 1=A2, 2=A3, 3=M1, 4=M2, 5=X1, 6=X2, 7=X3.
// PARAMETERS
// NUM_RAM_BANKS  4  number of CM-RAM lines; bank select is clog2(NUM_RAM_BANKS) bits
// PORTS
// clock            in   1   system clock; one clock, all state on posedge
// reset            in   1   synchronous, active-high
// cycle            in   3   current subcycle from cpu_control
// two_word         in   1   high while cpu_control is in the second word of a 2-word instruction
// pc               in   12  current program counter
// reg_out_enable   in   1   cpu_control requests index-register data on bus (FIN)
// reg_data         in   4   index register selected by cpu_control's inst_operand
// acc              in   4   accumulator value
// data_in          in   4   bus value sampled from pads
// data_out         out  4   bus value to pads
// data_oe          out  1   pad output enable
// cm_rom           out  1   ROM command line
// cm_ram           out  NUM_RAM_BANKS  RAM command lines, one-hot, selected bank only
// io_read_data     out  4   nibble captured in X2 of an I/O read
// io_read_valid    out  1   one-clock pulse when io_read_data updates
// BEHAVIOUR
// - Reset: data_oe=0, data_out=0, cm_rom=0, cm_ram=0, io_read_data=0, io_read_valid=0.
//   Internal state: opcode_q=8'h00, bank_q=0, io_mode=IDLE.
//   Reset mid-cycle aborts immediately. The first post-reset subcycle is A1.
// - data_out/data_oe: combinational from cycle and registered state.
//   - A1: oe=1, pc[3:0], or reg_data if reg_out_enable.
//   - A2: oe=1, pc[7:4], or reg_data if reg_out_enable.
//   - A3: oe=1, pc[11:8].
//   - M1, M2, X1: oe=0.
//   - X2/X3: per io_mode, below. Otherwise oe=0.
// - Opcode latch: opcode_q[7:4]<=data_in at end of M1; opcode_q[3:0]<=data_in at end of M2.
//   Both latches are suppressed while two_word=1, so opcode_q keeps word 1 through word 2.
// - io_mode: registered at end of X1 (cycle==5), from opcode_q with two_word=0.
//   - SRC (opcode_q[7:4]==4'h2, opcode_q[0]==1): X2 drives reg_data (first reg of pair);
//     X3 drives reg_data (second reg; cpu_control steers inst_operand).
//   - IO_WR (opcode_q in 8'hE0..8'hE7): X2 drives acc. X3 oe=0.
//   - IO_RD (8'hE8..8'hEF): oe=0 in X2/X3. io_read_data<=data_in at end of X2;
//     io_read_valid=1 during the following clock only.
//   - DCL (8'hFD): bank_q<=acc[clog2(NUM_RAM_BANKS)-1:0] at end of X1.
//     Bank indices >= NUM_RAM_BANKS wrap modulo NUM_RAM_BANKS.
//   - Otherwise IDLE. io_mode returns to IDLE at end of X3.
// - Command lines: registered, valid for the whole subcycle n, loaded on the edge where cycle becomes n.
//   - cm_rom=1 in A3 of every instruction cycle.
//   - cm_rom=1 in M2 when data_in==4'hE at end of M1 and two_word==0.
//   - cm_rom=1 in X2 when io_mode==SRC.
//   - cm_ram[bank_q] follows the same three conditions. All other cm_ram bits stay 0.
//   - A DCL's new bank takes effect from the next instruction's A3; the DCL's own X2 is unaffected.
// - Simultaneous: reg_out_enable outside A1/A2 is ignored. Second-word data of JUN/JMS/FIM/FIN
//   equal to 4'hE does not raise M2 command lines.
// - No bus contention: data_oe=0 in M1, M2, X1 unconditionally.
// STRUCTURE
// - New include bus.vh, next to datapath.vh:
//   - subcycle constants CYC_A1..CYC_X3
//   - io_mode encodings IO_IDLE/IO_SRC/IO_WR/IO_RD
//   - opcode constants OP_SRC_HI=4'h2, OP_IO_HI=4'hE, OP_DCL=8'hFD
// - One sub-module: cm_line_gen (cycle, io_mode, M1 nibble, two_word, bank_q -> registered cm_rom/cm_ram).
//   The bus mux and opcode/io state stay in cpu_bus_control.
// TESTING
// 1. Reset, pc=12'hABC, NOP: A1/A2/A3 data_out=C/B/A with oe=1; oe=0 M1-X3; cm_rom=1 in A3 only.
// 2. FIN word 2, reg_out_enable=1 in A1/A2, reg_data 5 then 7: bus shows 5,7,pc[11:8].
//    opcode_q unchanged across word 2.
// 3. SRC 8'h23, reg_data 9 (X2) then 4 (X3): data_out 9/4 with oe=1;
//    cm_rom=1 and cm_ram[0]=1 in X2 only.
// 4. DCL with acc=2, then WRM 8'hE0 with acc=6: next A3 has cm_ram=4'b0100;
//    M2 has cm_rom=1, cm_ram[2]=1; X2 data_out=6, oe=1.
// 5. RDR 8'hEA, peripheral drives 4'h3 in X2: io_read_data=3, io_read_valid pulses exactly one clock;
//    oe=0 throughout X2/X3.
// 6. JUN second word 8'hE5, then reset asserted at X2: no M2 cm lines.
//    After reset, all outputs 0 and the next cycle starts at A1.

Source files
------------

// File: rtl/cpu_bus_control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_bus_control_pkg
// Description : Shared constants for the CPU external bus controller: the
//               subcycle numbering, the I/O-mode encodings, the opcode values
//               the bus controller decodes, and the I/O-mode decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_bus_control_pkg;

    // Subcycle numbering of the shared 3-bit counter from cpu_control
    localparam logic [2:0] CYC_A1 = 3'd0;
    localparam logic [2:0] CYC_A2 = 3'd1;
    localparam logic [2:0] CYC_A3 = 3'd2;
    localparam logic [2:0] CYC_M1 = 3'd3;
    localparam logic [2:0] CYC_M2 = 3'd4;
    localparam logic [2:0] CYC_X1 = 3'd5;
    localparam logic [2:0] CYC_X2 = 3'd6;
    localparam logic [2:0] CYC_X3 = 3'd7;

    // What the bus does during X2/X3 of the current instruction
    localparam logic [1:0] IO_IDLE = 2'd0;
    localparam logic [1:0] IO_SRC  = 2'd1;
    localparam logic [1:0] IO_WR   = 2'd2;
    localparam logic [1:0] IO_RD   = 2'd3;

    // Opcode fields decoded by the bus controller
    localparam logic [3:0] OP_SRC_HI = 4'h2;
    localparam logic [3:0] OP_IO_HI  = 4'hE;
    localparam logic [7:0] OP_DCL    = 8'hFD;

    // SRC is 0x2 with an odd low nibble; 0xE0-0xE7 write, 0xE8-0xEF read.
    function automatic logic [1:0] decode_io_mode(input logic [7:0] opcode);
        logic [1:0] mode;
        mode = IO_IDLE;
        if ((opcode[7:4] == OP_SRC_HI) && opcode[0]) begin
            mode = IO_SRC;
        end else if (opcode[7:4] == OP_IO_HI) begin
            mode = opcode[3] ? IO_RD : IO_WR;
        end
        return mode;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cm_line_gen.sv
`default_nettype none
// ============================================================================
// Module      : cm_line_gen
// Description : Registered CM-ROM / CM-RAM command line generator. The lines
//               are computed one subcycle ahead and loaded on the edge where
//               the counter enters the subcycle they belong to, so they are
//               glitch-free for the whole subcycle.
// Revision    : 1.0 - initial release
// ============================================================================
module cm_line_gen
    import cpu_bus_control_pkg::*;
#(
    parameter int NUM_RAM_BANKS = 4,
    parameter int BANK_W        = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [2:0]               cycle_i,
    input  logic [1:0]               io_mode_next_i,
    input  logic [3:0]               m1_nibble_i,
    input  logic                     two_word_i,
    input  logic [BANK_W-1:0]        bank_i,
    output logic                     cm_rom_o,
    output logic [NUM_RAM_BANKS-1:0] cm_ram_o
);

    logic                     fire_d;
    logic [NUM_RAM_BANKS-1:0] cm_ram_d;
    logic                     cm_rom_q;
    logic [NUM_RAM_BANKS-1:0] cm_ram_q;

    // Decide whether the subcycle about to start carries a command strobe:
    // A3 always, M2 for an I/O-group opcode in word 1, X2 for SRC.
    always_comb begin
        fire_d = (cycle_i == CYC_A2)
               | ((cycle_i == CYC_M1) && (m1_nibble_i == OP_IO_HI) && !two_word_i)
               | ((cycle_i == CYC_X1) && (io_mode_next_i == IO_SRC));
        cm_ram_d = '0;
        for (int i = 0; i < NUM_RAM_BANKS; i++) begin
            cm_ram_d[i] = fire_d && (bank_i == BANK_W'(i));
        end
    end

    // Load the command lines for the next subcycle
    always_ff @(posedge clock) begin
        if (reset) begin
            cm_rom_q <= 1'b0;
            cm_ram_q <= '0;
        end else begin
            cm_rom_q <= fire_d;
            cm_ram_q <= cm_ram_d;
        end
    end

    assign cm_rom_o = cm_rom_q;
    assign cm_ram_o = cm_ram_q;

endmodule
`default_nettype wire

// File: rtl/cpu_bus_control.sv
`default_nettype none
// ============================================================================
// Module      : cpu_bus_control
// Description : Owner of the CPU's 4-bit multiplexed external bus. Chooses the
//               bus driver for every subcycle (PC / index registers during the
//               address phase, ROM during opcode fetch, CPU or peripheral
//               during execute), latches the opcode, tracks the I/O mode and
//               the DCL-selected RAM bank, and drives the CM command lines.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_bus_control
    import cpu_bus_control_pkg::*;
#(
    parameter int NUM_RAM_BANKS = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [2:0]               cycle,
    input  logic                     two_word,
    input  logic [11:0]              pc,
    input  logic                     reg_out_enable,
    input  logic [3:0]               reg_data,
    input  logic [3:0]               acc,
    input  logic [3:0]               data_in,
    output logic [3:0]               data_out,
    output logic                     data_oe,
    output logic                     cm_rom,
    output logic [NUM_RAM_BANKS-1:0] cm_ram,
    output logic [3:0]               io_read_data,
    output logic                     io_read_valid
);

    localparam int BANK_W = (NUM_RAM_BANKS > 1) ? $clog2(NUM_RAM_BANKS) : 1;

    logic [7:0]        opcode_q, opcode_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [1:0]        io_mode_q, io_mode_d;
    logic [3:0]        io_read_data_q, io_read_data_d;
    logic              io_read_valid_q, io_read_valid_d;

    logic [BANK_W-1:0] acc_bank;
    logic [BANK_W-1:0] acc_bank_wrapped;
    logic [3:0]        bus_data;
    logic              bus_oe;

    // DCL bank indices beyond the last bank fold back into range
    assign acc_bank         = acc[BANK_W-1:0];
    assign acc_bank_wrapped = (32'(acc_bank) >= 32'(NUM_RAM_BANKS))
                            ? (acc_bank - BANK_W'(NUM_RAM_BANKS))
                            : acc_bank;

    // Next-state for opcode latch, I/O mode, RAM bank and I/O read capture
    always_comb begin
        opcode_d        = opcode_q;
        bank_d          = bank_q;
        io_mode_d       = io_mode_q;
        io_read_data_d  = io_read_data_q;
        io_read_valid_d = 1'b0;

        // Second-word data is an operand, not an opcode: keep word 1
        if (!two_word) begin
            if (cycle == CYC_M1) opcode_d[7:4] = data_in;
            if (cycle == CYC_M2) opcode_d[3:0] = data_in;
        end

        if (cycle == CYC_X1) begin
            io_mode_d = two_word ? IO_IDLE : decode_io_mode(opcode_q);
            if (!two_word && (opcode_q == OP_DCL)) begin
                bank_d = acc_bank_wrapped;
            end
        end else if (cycle == CYC_X3) begin
            io_mode_d = IO_IDLE;
        end

        if ((cycle == CYC_X2) && (io_mode_q == IO_RD)) begin
            io_read_data_d  = data_in;
            io_read_valid_d = 1'b1;
        end
    end

    // Controller state registers
    always_ff @(posedge clock) begin
        if (reset) begin
            opcode_q        <= 8'h00;
            bank_q          <= '0;
            io_mode_q       <= IO_IDLE;
            io_read_data_q  <= 4'h0;
            io_read_valid_q <= 1'b0;
        end else begin
            opcode_q        <= opcode_d;
            bank_q          <= bank_d;
            io_mode_q       <= io_mode_d;
            io_read_data_q  <= io_read_data_d;
            io_read_valid_q <= io_read_valid_d;
        end
    end

    // Bus driver select; M1/M2/X1 never drive so ROM and peripherals own the bus
    always_comb begin
        bus_oe   = 1'b0;
        bus_data = 4'h0;
        if (!reset) begin
            case (cycle)
                CYC_A1: begin
                    bus_oe   = 1'b1;
                    bus_data = reg_out_enable ? reg_data : pc[3:0];
                end
                CYC_A2: begin
                    bus_oe   = 1'b1;
                    bus_data = reg_out_enable ? reg_data : pc[7:4];
                end
                CYC_A3: begin
                    bus_oe   = 1'b1;
                    bus_data = pc[11:8];
                end
                CYC_X2: begin
                    if (io_mode_q == IO_SRC) begin
                        bus_oe   = 1'b1;
                        bus_data = reg_data;
                    end else if (io_mode_q == IO_WR) begin
                        bus_oe   = 1'b1;
                        bus_data = acc;
                    end
                end
                CYC_X3: begin
                    if (io_mode_q == IO_SRC) begin
                        bus_oe   = 1'b1;
                        bus_data = reg_data;
                    end
                end
                default: begin
                    bus_oe   = 1'b0;
                    bus_data = 4'h0;
                end
            endcase
        end
    end

    cm_line_gen #(
        .NUM_RAM_BANKS (NUM_RAM_BANKS),
        .BANK_W        (BANK_W)
    ) u_cm_line_gen (
        .clock          (clock),
        .reset          (reset),
        .cycle_i        (cycle),
        .io_mode_next_i (io_mode_d),
        .m1_nibble_i    (data_in),
        .two_word_i     (two_word),
        .bank_i         (bank_q),
        .cm_rom_o       (cm_rom),
        .cm_ram_o       (cm_ram)
    );

    assign data_out      = bus_data;
    assign data_oe       = bus_oe;
    assign io_read_data  = io_read_data_q;
    assign io_read_valid = io_read_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_bus_control
// Description : Directed self-checking bench for cpu_bus_control. Each task
//               plays one or more instruction cycles, one clock per subcycle,
//               and compares a packed snapshot of the outputs per subcycle
//               against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_bus_control;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  cycle;
    logic        two_word;
    logic [11:0] pc;
    logic        reg_out_enable;
    logic [3:0]  reg_data;
    logic [3:0]  acc;
    logic [3:0]  data_in;
    logic [3:0]  data_out;
    logic        data_oe;
    logic        cm_rom;
    logic [3:0]  cm_ram;
    logic [3:0]  io_read_data;
    logic        io_read_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // Snapshot per subcycle: {oe, data_out (masked by oe), cm_rom, cm_ram, valid, io_read_data}
    logic [14:0] obs [8];
    logic [14:0] exp_t [8];
    logic [14:0] snap;

    always #5 clock = ~clock;

    cpu_bus_control #(.NUM_RAM_BANKS(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .cycle          (cycle),
        .two_word       (two_word),
        .pc             (pc),
        .reg_out_enable (reg_out_enable),
        .reg_data       (reg_data),
        .acc            (acc),
        .data_in        (data_in),
        .data_out       (data_out),
        .data_oe        (data_oe),
        .cm_rom         (cm_rom),
        .cm_ram         (cm_ram),
        .io_read_data   (io_read_data),
        .io_read_valid  (io_read_valid)
    );

    function automatic logic [14:0] ev(input logic oe, input logic [3:0] d, input logic rom,
                                       input logic [3:0] ram, input logic v, input logic [3:0] rd);
        return {oe, d, rom, ram, v, rd};
    endfunction

    // Plays the first n subcycles of one instruction cycle. Per-subcycle
    // nibbles are packed with subcycle i in bits [4i+3:4i].
    task automatic run_cycle(input int n, input logic [11:0] p, input logic tw,
                             input logic [7:0] reo, input logic [31:0] din,
                             input logic [31:0] rd, input logic [3:0] a);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            reset          = 1'b0;
            pc             = p;
            two_word       = tw;
            acc            = a;
            cycle          = 3'(i);
            data_in        = din[4*i +: 4];
            reg_data       = rd[4*i +: 4];
            reg_out_enable = reo[i];
            #1;
            obs[i] = {data_oe, data_out & {4{data_oe}}, cm_rom, cm_ram, io_read_valid, io_read_data};
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cycle = 3'd0; two_word = 1'b0; pc = 12'hABC;
        reg_out_enable = 1'b0; reg_data = 4'h0; acc = 4'h0; data_in = 4'hF;
        repeat (3) @(posedge clock);
        #1;
        snap = {data_oe, data_out, cm_rom, cm_ram, io_read_valid, io_read_data};
        n_checks++;
        if (snap !== 15'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required %h", snap, 15'h0);
        end
    endtask

    task automatic test_nop();
        run_cycle(8, 12'hABC, 1'b0, 8'h00, 32'h0, 32'h0, 4'h0);
        exp_t = '{ev(1,4'hC,0,4'h0,0,4'h0), ev(1,4'hB,0,4'h0,0,4'h0), ev(1,4'hA,1,4'h1,0,4'h0),
                  ev(0,4'h0,0,4'h0,0,4'h0), ev(0,4'h0,0,4'h0,0,4'h0), ev(0,4'h0,0,4'h0,0,4'h0),
                  ev(0,4'h0,0,4'h0,0,4'h0), ev(0,4'h0,0,4'h0,0,4'h0)};
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (obs[i] !== exp_t[i]) begin
                n_fail++;
                $display("FAIL nop_sub%0d: got %h required %h", i, obs[i], exp_t[i]);
            end
        end
    endtask

    task automatic test_fin();
        // Word 1: FIN 0x31
        run_cycle(8, 12'h123, 1'b0, 8'h00, 32'h0001_3000, 32'h0, 4'h0);
        exp_t = '{ev(1,4'h3,0,4'h0,0,4'h0), ev(1,4'h2,0,4'h0,0,4'h0), ev(1,4'h1,1,4'h1,0,4'h0),
                  ev(0,4'h0,0,4'h0,0,4'h0), ev(0,4'h0,0,4'h0,0,4'h0), ev(0,4'h0,0,4'h0,0,4'h0),
                  ev(0,4'h0,0,4'h0,0,4'h0), ev(0,4'h0,0,4'h0,0,4'h0)};
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (obs[i] !== exp_t[i]) begin
                n_fail++;
                $display("FAIL fin_w1_sub%0d: got %h required %h", i, obs[i], exp_t[i]);
            end
        end
        // Word 2: index data in A1/A2; enable also held in A3 where it must be ignored.
        // Word-2 data 0x23 would decode as SRC if it were latched.
        run_cycle(8, 12'h456, 1'b1, 8'h07, 32'h0003_2000, 32'h0000_0075, 4'h0);
        exp_t = '{ev(1,4'h5,0,4'h0,0,4'h0), ev(1,4'h7,0,4'h0,0,4'h0), ev(1,4'h4,1,4'h1,0,4'h0),
                  ev(0,4'h0,0,4'h0,0,4'h0), ev(0,4'h0,0,4'h0,0,4'h0), ev(0,4'h0,0,4'h0,0,4'h0),
                  ev(0,4'h0,0,4'h0,0,4'h0), ev(0,4'h0,0,4'h0,0,4'h0)};
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (obs[i] !== exp_t[i]) begin
                n_fail++;
                $display("FAIL fin_w2_sub%0d: got %h required %h", i, obs[i], exp_t[i]);
            end
        end
        n_checks++;
        if (dut.opcode_q !== 8'h31) begin
            n_fail++;
            $display("FAIL fin_opcode_hold: got %h required %h", dut.opcode_q, 8'h31);
        end
    endtask

    task automatic test_src();
        run_cycle(8, 12'h3F0, 1'b0, 8'h00, 32'h0003_2000, 32'h4900_0000, 4'h0);
        exp_t = '{ev(1,4'h0,0,4'h0,0,4'h0), ev(1,4'hF,0,4'h0,0,4'h0), ev(1,4'h3,1,4'h1,0,4'h0),
                  ev(0,4'h0,0,4'h0,0,4'h0), ev(0,4'h0,0,4'h0,0,4'h0), ev(0,4'h0,0,4'h0,0,4'h0),
                  ev(1,4'h9,1,4'h1,0,4'h0), ev(1,4'h4,0,4'h0,0,4'h0)};
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (obs[i] !== exp_t[i]) begin
                n_fail++;
                $display("FAIL src_sub%0d: got %h required %h", i, obs[i], exp_t[i]);
            end
        end
    endtask

    task automatic test_dcl_wrm();
        // DCL with acc=2: own cycle still uses bank 0
        run_cycle(8, 12'h010, 1'b0, 8'h00, 32'h000D_F000, 32'h0, 4'h2);
        exp_t = '{ev(1,4'h0,0,4'h0,0,4'h0), ev(1,4'h1,0,4'h0,0,4'h0), ev(1,4'h0,1,4'h1,0,4'h0),
                  ev(0,4'h0,0,4'h0,0,4'h0), ev(0,4'h0,0,4'h0,0,4'h0), ev(0,4'h0,0,4'h0,0,4'h0),
                  ev(0,4'h0,0,4'h0,0,4'h0), ev(0,4'h0,0,4'h0,0,4'h0)};
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (obs[i] !== exp_t[i]) begin
                n_fail++;
                $display("FAIL dcl_sub%0d: got %h required %h", i, obs[i], exp_t[i]);
            end
        end
        // WRM 0xE0 with acc=6 on bank 2
        run_cycle(8, 12'h011, 1'b0, 8'h00, 32'h0000_E000, 32'h0, 4'h6);
        exp_t = '{ev(1,4'h1,0,4'h0,0,4'h0), ev(1,4'h1,0,4'h0,0,4'h0), ev(1,4'h0,1,4'h4,0,4'h0),
                  ev(0,4'h0,0,4'h0,0,4'h0), ev(0,4'h0,1,4'h4,0,4'h0), ev(0,4'h0,0,4'h0,0,4'h0),
                  ev(1,4'h6,0,4'h0,0,4'h0), ev(0,4'h0,0,4'h0,0,4'h0)};
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (obs[i] !== exp_t[i]) begin
                n_fail++;
                $display("FAIL wrm_sub%0d: got %h required %h", i, obs[i], exp_t[i]);
            end
        end
    endtask

    task automatic test_rdr();
        // RDR 0xEA, peripheral drives 3 during X2
        run_cycle(8, 12'h222, 1'b0, 8'h00, 32'h030A_E000, 32'h0, 4'h0);
        exp_t = '{ev(1,4'h2,0,4'h0,0,4'h0), ev(1,4'h2,0,4'h0,0,4'h0), ev(1,4'h2,1,4'h4,0,4'h0),
                  ev(0,4'h0,0,4'h0,0,4'h0), ev(0,4'h0,1,4'h4,0,4'h0), ev(0,4'h0,0,4'h0,0,4'h0),
                  ev(0,4'h0,0,4'h0,0,4'h0), ev(0,4'h0,0,4'h0,1,4'h3)};
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (obs[i] !== exp_t[i]) begin
                n_fail++;
                $display("FAIL rdr_sub%0d: got %h required %h", i, obs[i], exp_t[i]);
            end
        end
        // Following NOP: valid has dropped, captured data holds
        run_cycle(8, 12'h000, 1'b0, 8'h00, 32'h0, 32'h0, 4'h0);
        exp_t[0] = ev(1,4'h0,0,4'h0,0,4'h3);
        exp_t[1] = ev(1,4'h0,0,4'h0,0,4'h3);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs[i] !== exp_t[i]) begin
                n_fail++;
                $display("FAIL rdr_after_sub%0d: got %h required %h", i, obs[i], exp_t[i]);
            end
        end
    endtask

    task automatic test_jun_reset();
        // JUN word 1 (0x40)
        run_cycle(8, 12'h333, 1'b0, 8'h00, 32'h0000_4000, 32'h0, 4'h0);
        exp_t[2] = ev(1,4'h3,1,4'h4,0,4'h3);
        n_checks++;
        if (obs[2] !== exp_t[2]) begin
            n_fail++;
            $display("FAIL jun_w1_a3: got %h required %h", obs[2], exp_t[2]);
        end
        // Word 2 = 0xE5: no M2 command strobe; stop after X1
        run_cycle(6, 12'h334, 1'b1, 8'h00, 32'h0005_E000, 32'h0, 4'h0);
        exp_t[2] = ev(1,4'h3,1,4'h4,0,4'h3);
        exp_t[4] = ev(0,4'h0,0,4'h0,0,4'h3);
        n_checks++;
        if (obs[2] !== exp_t[2]) begin
            n_fail++;
            $display("FAIL jun_w2_a3: got %h required %h", obs[2], exp_t[2]);
        end
        n_checks++;
        if (obs[4] !== exp_t[4]) begin
            n_fail++;
            $display("FAIL jun_w2_m2: got %h required %h", obs[4], exp_t[4]);
        end
        // Reset asserted in X2
        @(posedge clock);
        #1;
        reset = 1'b1; cycle = 3'd6; data_in = 4'h0;
        @(posedge clock);
        #1;
        cycle = 3'd0;
        #1;
        snap = {data_oe, data_out, cm_rom, cm_ram, io_read_valid, io_read_data};
        n_checks++;
        if (snap !== 15'h0) begin
            n_fail++;
            $display("FAIL jun_reset_outputs: got %h required %h", snap, 15'h0);
        end
        // Fresh cycle from A1: bank back to 0
        run_cycle(8, 12'h456, 1'b0, 8'h00, 32'h0, 32'h0, 4'h0);
        exp_t = '{ev(1,4'h6,0,4'h0,0,4'h0), ev(1,4'h5,0,4'h0,0,4'h0), ev(1,4'h4,1,4'h1,0,4'h0),
                  ev(0,4'h0,0,4'h0,0,4'h0), ev(0,4'h0,0,4'h0,0,4'h0), ev(0,4'h0,0,4'h0,0,4'h0),
                  ev(0,4'h0,0,4'h0,0,4'h0), ev(0,4'h0,0,4'h0,0,4'h0)};
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (obs[i] !== exp_t[i]) begin
                n_fail++;
                $display("FAIL post_reset_sub%0d: got %h required %h", i, obs[i], exp_t[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nop();
        test_fin();
        test_src();
        test_dcl_wrm();
        test_rdr();
        test_jun_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
